fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined MIPS core: owns the architectural PC, issues instruction-memory reads, and drives the IF/ID pipeline register consumed by decode. It takes the redirect target (`npc`) and the redirect flag (`branch`) produced by next-PC logic in ID and applies them after the delay slot. Variable-latency instruction memory and decode-stage stalls are absorbed by a one-entry hold buffer.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/if_id_reg.sv | 59 +++++
 rtl/fetch_stage.sv | 129 ++++++++++++
 tb/tb_fetch_stage.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the MIPS core pipeline front end.
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] LINK_OFFSET      = 32'd8;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_t;

  // Link address written by JAL/BGEZAL-style instructions: skips the delay slot.
  function automatic logic [31:0] link_addr(input logic [31:0] pc);
    return pc + LINK_OFFSET;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load a new instruction, insert a bubble, or hold.
module if_id_reg
  import cpu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        bubble_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_pc8_o,
  output logic        id_valid_o
);

  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc8_q, id_pc8_d;
  logic        id_valid_q, id_valid_d;

  // Load wins over bubble; a bubble keeps the PC fields so the link address stays stable.
  always_comb begin
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    id_pc8_d   = id_pc8_q;
    id_valid_d = id_valid_q;
    if (load_i) begin
      id_pc_d    = pc_i;
      id_instr_d = instr_i;
      id_pc8_d   = link_addr(pc_i);
      id_valid_d = 1'b1;
    end else if (bubble_i) begin
      id_instr_d = NOP_INSTR;
      id_valid_d = 1'b0;
    end
  end

  // Register update with asynchronous clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      id_pc_q    <= '0;
      id_instr_q <= NOP_INSTR;
      id_pc8_q   <= '0;
      id_valid_q <= 1'b0;
    end else begin
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
      id_pc8_q   <= id_pc8_d;
      id_valid_q <= id_valid_d;
    end
  end

  assign id_pc_o    = id_pc_q;
  assign id_instr_o = id_instr_q;
  assign id_pc8_o   = id_pc8_q;
  assign id_valid_o = id_valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, fetch FSM, one-entry hold buffer and
// delayed-branch redirect, feeding the IF/ID register.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch,
  input  logic [31:0] npc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc8,
  output logic        id_valid,
  output logic        fetch_busy
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  hold_instr_q, hold_instr_d;
  logic [31:0]  hold_pc_q, hold_pc_d;
  logic         redir_pend_q, redir_pend_d;
  logic [31:0]  redir_tgt_q, redir_tgt_d;

  logic         take;
  logic [31:0]  next_pc;
  logic         id_load;
  logic         id_bubble;
  logic [31:0]  id_load_pc;
  logic [31:0]  id_load_instr;

  // The branch in ID only redirects once it is real and allowed to advance.
  assign take    = branch & id_valid & ~stall;
  assign next_pc = take ? npc : (redir_pend_q ? redir_tgt_q : pc_q + PC_STEP);

  assign imem_req   = (state_q == FETCH);
  assign imem_addr  = pc_q;
  assign fetch_busy = (state_q == FETCH) & ~imem_ready;

  // Next-state, PC, hold-buffer and IF/ID control decisions.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    hold_instr_d  = hold_instr_q;
    hold_pc_d     = hold_pc_q;
    redir_pend_d  = redir_pend_q;
    redir_tgt_d   = redir_tgt_q;
    id_load       = 1'b0;
    id_bubble     = 1'b0;
    id_load_pc    = pc_q;
    id_load_instr = imem_rdata;
    unique case (state_q)
      FETCH: begin
        if (imem_ready) begin
          pc_d         = next_pc;
          redir_pend_d = 1'b0;
          if (stall) begin
            // ID is frozen: park the returned word until the stall drops.
            hold_instr_d = imem_rdata;
            hold_pc_d    = pc_q;
            state_d      = HOLD;
          end else begin
            id_load = 1'b1;
          end
        end else begin
          // Delay slot still outstanding: remember the target for later.
          if (take) begin
            redir_pend_d = 1'b1;
            redir_tgt_d  = npc;
          end
          id_bubble = ~stall;
        end
      end
      HOLD: begin
        if (!stall) begin
          id_load       = 1'b1;
          id_load_pc    = hold_pc_q;
          id_load_instr = hold_instr_q;
          state_d       = FETCH;
          // The parked word is the delay slot of a branch released with the stall.
          if (take) begin
            pc_d         = npc;
            redir_pend_d = 1'b0;
          end
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // Architectural fetch state with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      hold_instr_q <= NOP_INSTR;
      hold_pc_q    <= '0;
      redir_pend_q <= 1'b0;
      redir_tgt_q  <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      redir_pend_q <= redir_pend_d;
      redir_tgt_q  <= redir_tgt_d;
    end
  end

  if_id_reg u_if_id (
    .clk_i      (clk),
    .rst_ni     (reset),
    .load_i     (id_load),
    .bubble_i   (id_bubble),
    .pc_i       (id_load_pc),
    .instr_i    (id_load_instr),
    .id_pc_o    (id_pc),
    .id_instr_o (id_instr),
    .id_pc8_o   (id_pc8),
    .id_valid_o (id_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with an instruction-level reference model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch;
  logic [31:0] npc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        rdy;
  logic [31:0] imem_rdata;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [31:0] id_pc8;
  logic        id_valid;
  logic        fetch_busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Memory image: word at 0x3000 + 4k holds k+1.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return ((a - 32'h3000) >> 2) + 32'd1;
  endfunction

  assign imem_rdata = word_at(imem_addr);

  fetch_stage dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .branch     (branch),
    .npc        (npc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (rdy),
    .imem_rdata (imem_rdata),
    .id_pc      (id_pc),
    .id_instr   (id_instr),
    .id_pc8     (id_pc8),
    .id_valid   (id_valid),
    .fetch_busy (fetch_busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: what the fetch stage owes the pipeline, instruction by instruction.
  logic [31:0] m_pc, m_park_pc, m_park_word, m_tgt;
  logic [31:0] m_idpc, m_idinstr, m_idpc8;
  logic        m_idvalid, m_parked, m_pend;

  task automatic m_reset();
    m_pc = 32'h3000; m_parked = 1'b0; m_park_pc = '0; m_park_word = '0;
    m_pend = 1'b0; m_tgt = '0;
    m_idpc = '0; m_idinstr = '0; m_idpc8 = '0; m_idvalid = 1'b0;
  endtask

  task automatic m_enter_id(input logic [31:0] a, input logic [31:0] w);
    m_idpc = a; m_idinstr = w; m_idpc8 = a + 32'd8; m_idvalid = 1'b1;
  endtask

  task automatic m_step();
    logic        tk;
    logic [31:0] after;
    tk    = branch && m_idvalid && !stall;
    after = tk ? npc : (m_pend ? m_tgt : m_pc + 32'd4);
    if (m_parked) begin
      if (!stall) begin
        m_enter_id(m_park_pc, m_park_word);
        m_parked = 1'b0;
        if (tk) begin m_pc = npc; m_pend = 1'b0; end
      end
    end else if (rdy) begin
      if (stall) begin
        m_parked = 1'b1; m_park_pc = m_pc; m_park_word = word_at(m_pc);
      end else begin
        m_enter_id(m_pc, word_at(m_pc));
      end
      m_pc = after; m_pend = 1'b0;
    end else begin
      if (tk) begin m_pend = 1'b1; m_tgt = npc; end
      if (!stall) begin m_idvalid = 1'b0; m_idinstr = 32'h0; end
    end
  endtask

  // Cycle-by-cycle comparison of every output against the model.
  initial begin
    m_reset();
    forever begin
      @(negedge clk);
      if (!reset) m_reset();
      chk("m_imem_req",   {31'd0, imem_req},   {31'd0, !m_parked});
      chk("m_imem_addr",  imem_addr,           m_pc);
      chk("m_fetch_busy", {31'd0, fetch_busy}, {31'd0, !m_parked && !rdy});
      chk("m_id_pc",      id_pc,               m_idpc);
      chk("m_id_instr",   id_instr,            m_idinstr);
      chk("m_id_pc8",     id_pc8,              m_idpc8);
      chk("m_id_valid",   {31'd0, id_valid},   {31'd0, m_idvalid});
      @(posedge clk);
      if (!reset) m_reset();
      else        m_step();
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  typedef struct { logic r; logic s; logic b; logic [31:0] n; } vec_t;
  vec_t tbl [12];

  initial begin
    reset = 1'b0; stall = 1'b0; branch = 1'b0; npc = '0; rdy = 1'b1;
    cyc(); cyc(); #1;
    chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_id_instr", id_instr, 32'h0);
    chk("rst_id_pc8",   id_pc8,   32'h0);
    chk("rst_addr",     imem_addr, 32'h3000);
    #1 reset = 1'b1; #1;
    chk("rel_req",  {31'd0, imem_req}, 32'd1);
    chk("rel_addr", imem_addr, 32'h3000);

    // Zero-wait streaming.
    cyc(); #1;
    chk("s1_addr", imem_addr, 32'h3004);
    chk("s1_instr", id_instr, 32'h1);
    chk("s1_pc8", id_pc8, 32'h3008);
    cyc(); #1;
    chk("s2_addr", imem_addr, 32'h3008);
    chk("s2_instr", id_instr, 32'h2);
    chk("s2_pc", id_pc, 32'h3004);

    // Branch at 0x3004, delay slot ready immediately.
    branch = 1'b1; npc = 32'h3100;
    cyc(); #1;
    branch = 1'b0;
    chk("br_ds_pc", id_pc, 32'h3008);
    chk("br_ds_instr", id_instr, 32'h3);
    chk("br_ds_valid", {31'd0, id_valid}, 32'd1);
    chk("br_tgt_addr", imem_addr, 32'h3100);
    cyc(); #1;
    chk("br_tgt_pc", id_pc, 32'h3100);
    chk("br_tgt_instr", id_instr, 32'h41);

    // Branch with delay slot waiting three cycles.
    branch = 1'b1; npc = 32'h3200; rdy = 1'b0;
    cyc(); #1;
    branch = 1'b0;
    chk("wb_valid", {31'd0, id_valid}, 32'd0);
    chk("wb_instr", id_instr, 32'h0);
    chk("wb_pc", id_pc, 32'h3100);
    chk("wb_busy", {31'd0, fetch_busy}, 32'd1);
    chk("wb_addr", imem_addr, 32'h3104);
    cyc(); cyc(); #1;
    chk("wb3_valid", {31'd0, id_valid}, 32'd0);
    rdy = 1'b1;
    cyc(); #1;
    chk("wb_ds_pc", id_pc, 32'h3104);
    chk("wb_ds_instr", id_instr, 32'h42);
    chk("wb_tgt_addr", imem_addr, 32'h3200);
    cyc(); #1;
    chk("wb_tgt_pc", id_pc, 32'h3200);

    // Four-cycle stall while fetch of 0x3204 returns.
    stall = 1'b1;
    cyc(); #1;
    chk("st_req", {31'd0, imem_req}, 32'd0);
    chk("st_busy", {31'd0, fetch_busy}, 32'd0);
    chk("st_id_pc", id_pc, 32'h3200);
    cyc(); cyc(); cyc(); #1;
    chk("st4_id_instr", id_instr, 32'h81);
    stall = 1'b0;
    cyc(); #1;
    chk("st_rel_pc", id_pc, 32'h3204);
    chk("st_rel_instr", id_instr, 32'h82);
    chk("st_rel_pc8", id_pc8, 32'h320C);
    chk("st_rel_addr", imem_addr, 32'h3208);
    chk("st_rel_req", {31'd0, imem_req}, 32'd1);
    cyc(); #1;
    chk("st_next_pc", id_pc, 32'h3208);

    // Branch under stall: redirect only when the stall falls.
    branch = 1'b1; npc = 32'h3300; stall = 1'b1;
    cyc(); cyc(); #1;
    chk("bs_addr", imem_addr, 32'h3210);
    stall = 1'b0;
    cyc(); #1;
    branch = 1'b0;
    chk("bs_ds_pc", id_pc, 32'h320C);
    chk("bs_ds_instr", id_instr, 32'h84);
    chk("bs_tgt_addr", imem_addr, 32'h3300);
    cyc(); #1;
    chk("bs_tgt_instr", id_instr, 32'hC1);

    // Reach pc 0x3040, record a pending redirect, then reset mid-fetch.
    branch = 1'b1; npc = 32'h3040;
    cyc(); #1;
    chk("rm_addr", imem_addr, 32'h3040);
    npc = 32'h3500; rdy = 1'b0;
    cyc(); #1;
    branch = 1'b0;
    reset = 1'b0; #1;
    chk("rm_id_pc", id_pc, 32'h0);
    chk("rm_id_instr", id_instr, 32'h0);
    chk("rm_id_pc8", id_pc8, 32'h0);
    chk("rm_id_valid", {31'd0, id_valid}, 32'd0);
    chk("rm_addr_rst", imem_addr, 32'h3000);
    rdy = 1'b1;
    cyc();
    reset = 1'b1; #1;
    chk("rm_rel_addr", imem_addr, 32'h3000);
    cyc(); #1;
    chk("rm_first_pc", id_pc, 32'h3000);
    chk("rm_no_stale", imem_addr, 32'h3004);

    // Mixed directed sequence, checked by the model alone.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 32'h0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 32'h0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'h0};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 32'h3400};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 32'h0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'h0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 32'h3600};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 32'h3600};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 32'h3600};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 32'h0};
    for (int i = 0; i < 12; i++) begin
      rdy = tbl[i].r; stall = tbl[i].s; branch = tbl[i].b; npc = tbl[i].n;
      cyc();
    end
    rdy = 1'b1; stall = 1'b0; branch = 1'b0;
    cyc(); cyc();
    @(negedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
